// File: rtl/floor_arb.sv
// Two-port round-robin arbiter in front of a shared, fixed-latency floor unit.
// Each port holds a 2-entry response FIFO, and per-port credits keep issue from overrunning it.
module floor_arb #(
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    input  logic        rsp1_ready,
    output logic [31:0] fu_in,
    input  logic [31:0] fu_out
);

    logic [1:0]     req_valid;
    logic [1:0]     rsp_ready;
    logic [1:0]     elig;
    logic [1:0]     grant;
    logic [1:0]     push;
    logic [1:0]     pop;
    logic           last_grant;
    logic [LAT-1:0] pipe_v;
    logic [LAT-1:0] pipe_tag;
    logic [1:0]     occ  [2];
    logic [1:0]     infl [2];
    logic           wp   [2];
    logic           rp   [2];
    logic [31:0]    mem  [2][2];

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    always_comb begin
        elig  = '0;
        push  = '0;
        pop   = '0;
        grant = '0;
        fu_in = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            // rstn gates eligibility so ready stays low while reset is held
            elig[p] = rstn && req_valid[p] && ((3'(occ[p]) + 3'(infl[p])) < 3'd2);
            push[p] = pipe_v[LAT-1] && (pipe_tag[LAT-1] == 1'(p));
            pop[p]  = (occ[p] != 2'd0) && rsp_ready[p];
        end
        if (&elig) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = elig;
        end
        if (grant[0]) begin
            fu_in = req0_data;
        end else if (grant[1]) begin
            fu_in = req1_data;
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = (occ[0] != 2'd0);
    assign rsp1_valid = (occ[1] != 2'd0);
    assign rsp0_data  = mem[0][rp[0]];
    assign rsp1_data  = mem[1][rp[1]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= 1'b1;
            pipe_v     <= '0;
            pipe_tag   <= '0;
            for (int unsigned p = 0; p < 2; p++) begin
                occ[p]    <= '0;
                infl[p]   <= '0;
                wp[p]     <= 1'b0;
                rp[p]     <= 1'b0;
                mem[p][0] <= '0;
                mem[p][1] <= '0;
            end
        end else begin
            if (|grant) begin
                last_grant <= grant[1];
            end
            pipe_v[0]   <= |grant;
            pipe_tag[0] <= grant[1];
            for (int unsigned i = 1; i < LAT; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
            for (int unsigned p = 0; p < 2; p++) begin
                if (push[p]) begin
                    mem[p][wp[p]] <= fu_out;
                    wp[p]         <= ~wp[p];
                end
                if (pop[p]) begin
                    rp[p] <= ~rp[p];
                end
                case ({push[p], pop[p]})
                    2'b10:   occ[p] <= occ[p] + 2'd1;
                    2'b01:   occ[p] <= occ[p] - 2'd1;
                    default: occ[p] <= occ[p];
                endcase
                case ({grant[p], push[p]})
                    2'b10:   infl[p] <= infl[p] + 2'd1;
                    2'b01:   infl[p] <= infl[p] - 2'd1;
                    default: infl[p] <= infl[p];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_floor_arb.sv
// Directed bench for floor_arb: instance A (LAT=1) runs the directed scenarios, and
// instance B (LAT=3) runs the reset-flush and scoreboarded mixed-traffic scenarios.
module tb_floor_arb;

    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic        req0_valid_a = 0, req1_valid_a = 0, rsp0_ready_a = 0, rsp1_ready_a = 0;
    logic [31:0] req0_data_a = '0, req1_data_a = '0;
    logic        req0_ready_a, req1_ready_a, rsp0_valid_a, rsp1_valid_a;
    logic [31:0] rsp0_data_a, rsp1_data_a, fu_in_a, fu_out_a;
    logic [31:0] fa_q = '0;

    logic        req0_valid_b = 0, req1_valid_b = 0, rsp0_ready_b = 0, rsp1_ready_b = 0;
    logic [31:0] req0_data_b = '0, req1_data_b = '0;
    logic        req0_ready_b, req1_ready_b, rsp0_valid_b, rsp1_valid_b;
    logic [31:0] rsp0_data_b, rsp1_data_b, fu_in_b, fu_out_b;
    logic [31:0] fb_q [3] = '{default: '0};

    always #5 clk = ~clk;

    function automatic logic [31:0] floor_f(input logic [31:0] x);
        logic [7:0]  e;
        logic [31:0] mask;
        int unsigned fb;
        e = x[30:23];
        if (e >= 8'd150) return x;
        if (e < 8'd127) begin
            if (x[30:0] == 31'd0) return x;
            return x[31] ? 32'hBF80_0000 : 32'h0000_0000;
        end
        fb   = 32'd150 - 32'(e);
        mask = (32'd1 << fb) - 32'd1;
        if ((x & mask) == 32'd0) return x;
        return x[31] ? ((x & ~mask) + (32'd1 << fb)) : (x & ~mask);
    endfunction

    // Behavioural floor units with 1 and 3 cycle latency
    always @(posedge clk) begin
        fa_q    <= fu_in_a;
        fb_q[0] <= fu_in_b;
        fb_q[1] <= fb_q[0];
        fb_q[2] <= fb_q[1];
    end
    always_comb fu_out_a = floor_f(fa_q);
    always_comb fu_out_b = floor_f(fb_q[2]);

    floor_arb #(.LAT(1)) dut_a (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid_a), .req0_data(req0_data_a), .req0_ready(req0_ready_a),
        .req1_valid(req1_valid_a), .req1_data(req1_data_a), .req1_ready(req1_ready_a),
        .rsp0_valid(rsp0_valid_a), .rsp0_data(rsp0_data_a), .rsp0_ready(rsp0_ready_a),
        .rsp1_valid(rsp1_valid_a), .rsp1_data(rsp1_data_a), .rsp1_ready(rsp1_ready_a),
        .fu_in(fu_in_a), .fu_out(fu_out_a)
    );

    floor_arb #(.LAT(3)) dut_b (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid_b), .req0_data(req0_data_b), .req0_ready(req0_ready_b),
        .req1_valid(req1_valid_b), .req1_data(req1_data_b), .req1_ready(req1_ready_b),
        .rsp0_valid(rsp0_valid_b), .rsp0_data(rsp0_data_b), .rsp0_ready(rsp0_ready_b),
        .rsp1_valid(rsp1_valid_b), .rsp1_data(rsp1_data_b), .rsp1_ready(rsp1_ready_b),
        .fu_in(fu_in_b), .fu_out(fu_out_b)
    );

    task automatic idle_inputs();
        req0_valid_a = 0; req1_valid_a = 0; rsp0_ready_a = 0; rsp1_ready_a = 0;
        req0_valid_b = 0; req1_valid_b = 0; rsp0_ready_b = 0; rsp1_ready_b = 0;
        req0_data_a = '0; req1_data_a = '0; req0_data_b = '0; req1_data_b = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        req0_valid_a = 1; req1_valid_a = 1; req0_data_a = 32'h4020_0000; req1_data_a = 32'hBF00_0000;
        req0_valid_b = 1; req1_valid_b = 1; req0_data_b = 32'h4020_0000;
        @(negedge clk);
        n_checks++; if (req0_ready_a !== 1'b0) begin n_fail++; $display("FAIL rst_req0_ready: got %b expected 0", req0_ready_a); end
        n_checks++; if (req1_ready_a !== 1'b0) begin n_fail++; $display("FAIL rst_req1_ready: got %b expected 0", req1_ready_a); end
        n_checks++; if (rsp0_valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_rsp0_valid: got %b expected 0", rsp0_valid_a); end
        n_checks++; if (rsp1_valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_rsp1_valid: got %b expected 0", rsp1_valid_a); end
        n_checks++; if (rsp0_data_a !== 32'h0) begin n_fail++; $display("FAIL rst_rsp0_data: got %h expected 0", rsp0_data_a); end
        n_checks++; if (rsp1_data_a !== 32'h0) begin n_fail++; $display("FAIL rst_rsp1_data: got %h expected 0", rsp1_data_a); end
        n_checks++; if (fu_in_a !== 32'h0) begin n_fail++; $display("FAIL rst_fu_in_a: got %h expected 0", fu_in_a); end
        n_checks++; if (req0_ready_b !== 1'b0) begin n_fail++; $display("FAIL rst_req0_ready_b: got %b expected 0", req0_ready_b); end
        n_checks++; if (fu_in_b !== 32'h0) begin n_fail++; $display("FAIL rst_fu_in_b: got %h expected 0", fu_in_b); end
        @(posedge clk); #1;
        idle_inputs();
        rstn = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req0_valid_a = 1; req0_data_a = 32'h4020_0000; rsp0_ready_a = 1;
        @(negedge clk);
        n_checks++; if (req0_ready_a !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", req0_ready_a); end
        n_checks++; if (fu_in_a !== 32'h4020_0000) begin n_fail++; $display("FAIL single_fu_in: got %h expected 40200000", fu_in_a); end
        @(posedge clk); #1;
        req0_valid_a = 0;
        @(negedge clk);
        n_checks++; if (rsp0_valid_a !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", rsp0_valid_a); end
        n_checks++; if (fu_in_a !== 32'h0) begin n_fail++; $display("FAIL single_fu_in_idle: got %h expected 0", fu_in_a); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (rsp0_valid_a !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", rsp0_valid_a); end
        n_checks++; if (rsp0_data_a !== 32'h4000_0000) begin n_fail++; $display("FAIL single_data: got %h expected 40000000", rsp0_data_a); end
        n_checks++; if (rsp1_valid_a !== 1'b0) begin n_fail++; $display("FAIL single_no_cross: got %b expected 0", rsp1_valid_a); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (rsp0_valid_a !== 1'b0) begin n_fail++; $display("FAIL single_popped: got %b expected 0", rsp0_valid_a); end
        @(posedge clk); #1;
    endtask

    task automatic test_alternate();
        int n0 = 0, n1 = 0;
        do_reset();
        req0_valid_a = 1; req0_data_a = 32'hC020_0000; rsp0_ready_a = 1;
        req1_valid_a = 1; req1_data_a = 32'hBF00_0000; rsp1_ready_a = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 8) begin
                n_checks++; if (req0_ready_a !== ((c % 2) == 0)) begin n_fail++; $display("FAIL alt_grant0 c%0d: got %b expected %b", c, req0_ready_a, (c % 2) == 0); end
                n_checks++; if (req1_ready_a !== ((c % 2) == 1)) begin n_fail++; $display("FAIL alt_grant1 c%0d: got %b expected %b", c, req1_ready_a, (c % 2) == 1); end
                n_checks++; if (fu_in_a !== (((c % 2) == 0) ? 32'hC020_0000 : 32'hBF00_0000)) begin n_fail++; $display("FAIL alt_fu_in c%0d: got %h", c, fu_in_a); end
            end
            if (rsp0_valid_a) begin
                n0++;
                n_checks++; if (rsp0_data_a !== 32'hC040_0000) begin n_fail++; $display("FAIL alt_rsp0: got %h expected c0400000", rsp0_data_a); end
            end
            if (rsp1_valid_a) begin
                n1++;
                n_checks++; if (rsp1_data_a !== 32'hBF80_0000) begin n_fail++; $display("FAIL alt_rsp1: got %h expected bf800000", rsp1_data_a); end
            end
            @(posedge clk); #1;
            if (c == 7) begin req0_valid_a = 0; req1_valid_a = 0; end
        end
        n_checks++; if (n0 !== 4) begin n_fail++; $display("FAIL alt_count0: got %0d expected 4", n0); end
        n_checks++; if (n1 !== 4) begin n_fail++; $display("FAIL alt_count1: got %0d expected 4", n1); end
    endtask

    task automatic test_backpressure();
        int acc0 = 0, acc1 = 0;
        do_reset();
        req0_valid_a = 1; req0_data_a = 32'h4020_0000; rsp0_ready_a = 1;
        req1_valid_a = 1; req1_data_a = 32'h3FE0_0000; rsp1_ready_a = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (req0_ready_a) acc0++;
            if (req1_ready_a) acc1++;
            if (rsp0_valid_a) begin
                n_checks++; if (rsp0_data_a !== 32'h4000_0000) begin n_fail++; $display("FAIL bp_rsp0: got %h expected 40000000", rsp0_data_a); end
            end
            if (c >= 4) begin
                n_checks++; if (req1_ready_a !== 1'b0) begin n_fail++; $display("FAIL bp_req1_blocked c%0d: got %b expected 0", c, req1_ready_a); end
            end
            @(posedge clk); #1;
        end
        n_checks++; if (acc1 !== 2) begin n_fail++; $display("FAIL bp_acc1: got %0d expected 2", acc1); end
        n_checks++; if (acc0 !== 5) begin n_fail++; $display("FAIL bp_acc0: got %0d expected 5", acc0); end
        rsp1_ready_a = 1;
        @(negedge clk);
        n_checks++; if (rsp1_valid_a !== 1'b1) begin n_fail++; $display("FAIL bp_rsp1_valid_a: got %b expected 1", rsp1_valid_a); end
        n_checks++; if (rsp1_data_a !== 32'h3F80_0000) begin n_fail++; $display("FAIL bp_rsp1_data_a: got %h expected 3f800000", rsp1_data_a); end
        n_checks++; if (req1_ready_a !== 1'b0) begin n_fail++; $display("FAIL bp_credit_same_cycle: got %b expected 0", req1_ready_a); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (rsp1_valid_a !== 1'b1) begin n_fail++; $display("FAIL bp_rsp1_valid_b: got %b expected 1", rsp1_valid_a); end
        n_checks++; if (rsp1_data_a !== 32'h3F80_0000) begin n_fail++; $display("FAIL bp_rsp1_data_b: got %h expected 3f800000", rsp1_data_a); end
        n_checks++; if (req1_ready_a !== 1'b1) begin n_fail++; $display("FAIL bp_resume: got %b expected 1", req1_ready_a); end
        @(posedge clk); #1;
        req0_valid_a = 0; req1_valid_a = 0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_full_fifo();
        int k = 0, rx = 0;
        logic acc;
        do_reset();
        req0_valid_a = 1; req0_data_a = 32'h4300_8000; rsp0_ready_a = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            acc = req0_ready_a;
            if (c == 4) begin
                n_checks++; if (req0_ready_a !== 1'b0) begin n_fail++; $display("FAIL full_blocked: got %b expected 0", req0_ready_a); end
                n_checks++; if (req1_ready_a !== 1'b0) begin n_fail++; $display("FAIL full_req1_idle: got %b expected 0", req1_ready_a); end
            end
            @(posedge clk); #1;
            if (acc) begin k++; req0_data_a = 32'h4300_8000 + (32'(k) << 17); end
        end
        n_checks++; if (k !== 2) begin n_fail++; $display("FAIL full_fill: got %0d expected 2", k); end
        rsp0_ready_a = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            acc = req0_valid_a && req0_ready_a;
            if (c == 0) begin
                n_checks++; if (req0_ready_a !== 1'b0) begin n_fail++; $display("FAIL full_no_comb_credit: got %b expected 0", req0_ready_a); end
            end
            if (c == 1) begin
                n_checks++; if (req0_ready_a !== 1'b1) begin n_fail++; $display("FAIL full_credit_next: got %b expected 1", req0_ready_a); end
            end
            if (rsp0_valid_a) begin
                n_checks++; if (rsp0_data_a !== 32'h4300_0000 + (32'(rx) << 17)) begin n_fail++; $display("FAIL full_order #%0d: got %h expected %h", rx, rsp0_data_a, 32'h4300_0000 + (32'(rx) << 17)); end
                rx++;
            end
            @(posedge clk); #1;
            if (acc) begin k++; req0_data_a = 32'h4300_8000 + (32'(k) << 17); end
            if (c == 13) req0_valid_a = 0;
        end
        n_checks++; if (rx !== k) begin n_fail++; $display("FAIL full_no_loss: got %0d results expected %0d", rx, k); end
    endtask

    task automatic test_reset_flush();
        do_reset();
        req0_valid_b = 1; req0_data_b = 32'h4020_0000;
        req1_valid_b = 1; req1_data_b = 32'h3FE0_0000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++; if ({req1_ready_b, req0_ready_b} !== (((c % 2) == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL flush_grant c%0d: got %b", c, {req1_ready_b, req0_ready_b}); end
            @(posedge clk); #1;
        end
        req0_valid_b = 0; req1_valid_b = 0;
        @(negedge clk);
        n_checks++; if (rsp0_valid_b !== 1'b1) begin n_fail++; $display("FAIL flush_buffered: got %b expected 1", rsp0_valid_b); end
        rstn = 1'b0;
        #1;
        n_checks++; if (rsp0_valid_b !== 1'b0) begin n_fail++; $display("FAIL flush_rsp0_valid: got %b expected 0", rsp0_valid_b); end
        n_checks++; if (rsp1_valid_b !== 1'b0) begin n_fail++; $display("FAIL flush_rsp1_valid: got %b expected 0", rsp1_valid_b); end
        n_checks++; if (rsp0_data_b !== 32'h0) begin n_fail++; $display("FAIL flush_rsp0_data: got %h expected 0", rsp0_data_b); end
        @(posedge clk); #1;
        rstn = 1'b1;
        rsp0_ready_b = 1; rsp1_ready_b = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++; if ({rsp1_valid_b, rsp0_valid_b} !== 2'b00) begin n_fail++; $display("FAIL flush_stale c%0d: got %b expected 00", c, {rsp1_valid_b, rsp0_valid_b}); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mixed_lat3();
        logic [31:0] q0 [$];
        logic [31:0] q1 [$];
        logic a0, a1;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            a0 = req0_valid_b && req0_ready_b;
            a1 = req1_valid_b && req1_ready_b;
            n_checks++; if (fu_in_b !== (a0 ? req0_data_b : (a1 ? req1_data_b : 32'h0)) || (a0 && a1)) begin n_fail++; $display("FAIL mix_issue c%0d: got %h grants %b%b", c, fu_in_b, a1, a0); end
            if (a0) q0.push_back(floor_f(req0_data_b));
            if (a1) q1.push_back(floor_f(req1_data_b));
            if (rsp0_valid_b && rsp0_ready_b) begin
                n_checks++;
                if (q0.size() == 0) begin n_fail++; $display("FAIL mix_rsp0_extra c%0d: got %h expected nothing", c, rsp0_data_b); end
                else begin
                    if (rsp0_data_b !== q0[0]) begin n_fail++; $display("FAIL mix_rsp0 c%0d: got %h expected %h", c, rsp0_data_b, q0[0]); end
                    void'(q0.pop_front());
                end
            end
            if (rsp1_valid_b && rsp1_ready_b) begin
                n_checks++;
                if (q1.size() == 0) begin n_fail++; $display("FAIL mix_rsp1_extra c%0d: got %h expected nothing", c, rsp1_data_b); end
                else begin
                    if (rsp1_data_b !== q1[0]) begin n_fail++; $display("FAIL mix_rsp1 c%0d: got %h expected %h", c, rsp1_data_b, q1[0]); end
                    void'(q1.pop_front());
                end
            end
            @(posedge clk); #1;
            if (c < 1480) begin
                if (!req0_valid_b || a0) begin req0_valid_b = 1'($urandom_range(0, 1)); req0_data_b = $urandom; end
                if (!req1_valid_b || a1) begin req1_valid_b = 1'($urandom_range(0, 1)); req1_data_b = $urandom; end
                rsp0_ready_b = 1'($urandom_range(0, 1));
                rsp1_ready_b = 1'($urandom_range(0, 1));
            end else begin
                if (a0) req0_valid_b = 0;
                if (a1) req1_valid_b = 0;
                if (!req0_valid_b && !req1_valid_b) begin rsp0_ready_b = 1; rsp1_ready_b = 1; end
            end
        end
        n_checks++; if (q0.size() !== 0) begin n_fail++; $display("FAIL mix_loss0: got %0d outstanding expected 0", q0.size()); end
        n_checks++; if (q1.size() !== 0) begin n_fail++; $display("FAIL mix_loss1: got %0d outstanding expected 0", q1.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_full_fifo();
        test_reset_flush();
        test_mixed_lat3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
